// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serializes whole messages from NUM_REQ sources into
// the UART TX FIFO write port as a header byte followed by MSB-first payload bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MSG_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*MSG_BYTES*8-1:0] msg_data,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           fifo_full,
  output logic                           tx_we,
  output logic [7:0]                     tx_data,
  output logic                           busy,
  output logic [3:0]                     grant_id
);

  localparam int PW = MSG_BYTES * 8;
  localparam int SW = PW + 8;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [SW-1:0]        shift_r;
  logic [4:0]           cnt_r;
  logic [3:0]           last_r;
  logic [3:0]           grant_id_r;
  logic [NUM_REQ-1:0]   ack_r;

  logic                 hi_found_s;
  logic                 lo_found_s;
  logic                 found_s;
  logic [3:0]           hi_win_s;
  logic [3:0]           lo_win_s;
  logic [3:0]           winner_s;
  logic [PW-1:0]        hi_data_s;
  logic [PW-1:0]        lo_data_s;
  logic [PW-1:0]        win_data_s;
  logic [NUM_REQ-1:0]   hi_ack_s;
  logic [NUM_REQ-1:0]   lo_ack_s;
  logic [NUM_REQ-1:0]   win_ack_s;

  // Round-robin pick: first requester above last, otherwise first at or below last.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_win_s   = 4'd0;
    lo_win_s   = 4'd0;
    hi_data_s  = '0;
    lo_data_s  = '0;
    hi_ack_s   = '0;
    lo_ack_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hi_found_s && req[i] && (i > int'(last_r))) begin
        hi_found_s  = 1'b1;
        hi_win_s    = 4'(i);
        hi_data_s   = msg_data[i*PW +: PW];
        hi_ack_s[i] = 1'b1;
      end else begin
        hi_found_s = hi_found_s;
      end
      if (!lo_found_s && req[i] && (i <= int'(last_r))) begin
        lo_found_s  = 1'b1;
        lo_win_s    = 4'(i);
        lo_data_s   = msg_data[i*PW +: PW];
        lo_ack_s[i] = 1'b1;
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    found_s = hi_found_s | lo_found_s;
    if (hi_found_s) begin
      winner_s   = hi_win_s;
      win_data_s = hi_data_s;
      win_ack_s  = hi_ack_s;
    end else begin
      winner_s   = lo_win_s;
      win_data_s = lo_data_s;
      win_ack_s  = lo_ack_s;
    end
  end

  // Write strobe is combinational so a full FIFO stalls the current byte in the same cycle.
  assign tx_we    = (state_r == SEND) && !fifo_full;
  assign tx_data  = shift_r[SW-1 -: 8];
  assign busy     = (state_r == SEND);
  assign grant_id = grant_id_r;
  assign ack      = ack_r;

  // Next-state selection.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_next_s = SEND;
        end else begin
          state_next_s = IDLE;
        end
      end
      SEND: begin
        if (tx_we && (cnt_r == 5'd0)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SEND;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Message capture, byte shifting, pointer and ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r    <= '0;
      cnt_r      <= 5'd0;
      last_r     <= 4'(NUM_REQ - 1);
      grant_id_r <= 4'd0;
      ack_r      <= '0;
    end else begin
      ack_r <= '0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            shift_r    <= {8'hA0 | {4'h0, winner_s}, win_data_s};
            cnt_r      <= 5'(MSG_BYTES);
            last_r     <= winner_s;
            grant_id_r <= winner_s;
            ack_r      <= win_ack_s;
          end
        end
        SEND: begin
          if (tx_we) begin
            shift_r <= {shift_r[SW-9:0], 8'h00};
            if (cnt_r != 5'd0) begin
              cnt_r <= cnt_r - 5'd1;
            end
          end
        end
        default: begin
          shift_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART TX FIFO write port between NUM_REQ message sources, for example the golden-nonce reporter and the status/heartbeat reporter.
- Grants one whole message at a time in round-robin order, so messages from different sources never interleave.
- Serializes each granted message into a header byte followed by MSG_BYTES payload bytes, most-significant byte first.
- Throttles writes on the FIFO's full indication so that no byte is ever dropped.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..16.
MSG_BYTES, 4, payload bytes per message; legal range 1..16.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
req  input  NUM_REQ  per-source request; held high until the matching ack.
msg_data  input  NUM_REQ*MSG_BYTES*8  source i payload at bits [i*MSG_BYTES*8 +: MSG_BYTES*8].
ack  output  NUM_REQ  one-cycle pulse; the source's payload has been captured.
fifo_full  input  1  high when the FIFO cannot accept a write this cycle.
tx_we  output  1  FIFO write strobe.
tx_data  output  8  FIFO write byte.
busy  output  1  high while a message is being sent (state SEND).
grant_id  output  4  index of the current or last granted source.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low (rst_n); the clock port is clk.
- Reset values:
  - state=IDLE, ack=0, tx_we=0, tx_data=0, busy=0, grant_id=0.
  - shift register=0, byte counter=0.
  - round-robin pointer last=NUM_REQ-1, so source 0 wins the first tie.
- Reset mid-operation:
  - Asserting rst_n low aborts a message immediately, and tx_we drops without a clock edge.
  - The partial message is not resumed.
  - A source whose ack already fired is not re-acked.
- States: IDLE and SEND.
- IDLE:
  - If any req bit is high, select the winner by searching from last+1 upward and wrapping modulo NUM_REQ.
  - On that clock edge:
    - load the shift register with {8'hA0 | winner[3:0], msg_data slice of the winner};
    - set byte counter = MSG_BYTES;
    - set last and grant_id to the winner;
    - assert ack[winner] for exactly one cycle;
    - go to SEND.
  - With no req, stay in IDLE.
- SEND:
  - tx_we = ~fifo_full, combinational from state and fifo_full.
  - tx_data = top byte of the shift register. It is registered data, stable while fifo_full stalls.
  - On an edge where tx_we=1:
    - shift left by 8;
    - if the counter is 0, go to IDLE; otherwise decrement the counter.
  - On an edge where fifo_full=1, hold everything.
- Latency and throughput:
  - Req sampled in cycle N gives ack and the header write in cycle N+1 (if not full).
  - The message takes MSG_BYTES+1 write cycles.
  - At least one IDLE cycle separates consecutive messages.
  - Peak rate is (MSG_BYTES+1) bytes per (MSG_BYTES+2) cycles.
- Handshake rules:
  - msg_data is sampled only at the grant edge, so a source may change it after ack.
  - req still high in the cycle after ack counts as a new request. Sources must drop req on ack.
  - req falling before grant is silently withdrawn.
  - req changing during SEND has no effect until IDLE.
- Simultaneous events:
  - fifo_full rising in the same cycle as the last byte means no write; the last byte is retried.
  - req from the source just served competes only after all other pending sources (round-robin fairness).
- Width rules:
  - The counter is 5 bits and the pointer is 4 bits.
  - The winner index is zero-extended into the header low nibble.
  - grant_id high bits are 0 when NUM_REQ<16.

Test Plan:
- Reset, then req=2'b01 with msg0=32'hDEADBEEF and fifo_full=0:
  - ack[0] pulses in cycle 1;
  - tx_data sequence is A0, DE, AD, BE, EF on consecutive tx_we cycles;
  - busy is high for 5 cycles, then returns to IDLE.
- req=2'b11 held until ack, msg0=11223344, msg1=55667788:
  - order is A0 11 22 33 44, then A1 55 66 77 88;
  - exactly one idle cycle between the messages;
  - ack[0] first, then ack[1].
- fifo_full high for 3 cycles after the header byte:
  - tx_we stays 0 and tx_data holds DE;
  - the transfer resumes and the byte count totals exactly 5, with no duplicate or lost byte.
- Both sources keep re-requesting continuously for 6 messages:
  - grants alternate 0,1,0,1,0,1;
  - header bytes alternate A0/A1.
- rst_n pulsed low after 2 bytes of a message:
  - tx_we is 0 during reset;
  - after release, with req0 re-raised, the full 5-byte message restarts from header A0.
- req0 pulsed one cycle during SEND of source 1, then dropped:
  - the pulse is never acked;
  - no extra bytes are written.
